lif_neuron_array: RTL

Parametrised multi-channel leaky integrate-and-fire neuron array: the next generation of our single-neuron LIF block. It adds a configurable channel count and data width, a runtime threshold, output saturation, and an optional refractory period. One step handshake launches a time-multiplexed sweep that updates every channel through a single shared datapath. It sits between the input-current registers (`ui_in` / `uio_in` in the tile wrapper) and the spike outputs (`uo_out`).

---
 rtl/lif_pkg.sv | 28 ++
 rtl/lif_update.sv | 52 +++++
 rtl/lif_neuron_array.sv | 127 ++++++++++++
 3 files changed

// File: rtl/lif_pkg.sv
// Shared types and helpers for the LIF neuron array.
// FSM encoding, select-width helper and saturating adder.
package lif_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } lif_state_t;

  function automatic int LIF_IDX_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Unsigned add clamped to 2^w-1 (w <= 31).
  function automatic logic [31:0] lif_sat_add(
    input logic [31:0] a,
    input logic [31:0] b,
    input int          w
  );
    logic [32:0] s;
    logic [32:0] mx;
    s  = {1'b0, a} + {1'b0, b};
    mx = (33'd1 << w) - 33'd1;
    return (s > mx) ? 32'(mx) : 32'(s);
  endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational single-channel LIF datapath.
// LIF_REFRACTORY_EN adds the refractory counter path.
module lif_update
  import lif_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LEAK_SHIFT = 1
`ifdef LIF_REFRACTORY_EN
  ,
  parameter int REFRAC     = 2,
  parameter int RW         = 2
`endif
) (
  input  logic [WIDTH-1:0] mem_i,
  input  logic [WIDTH-1:0] cur_i,
  input  logic [WIDTH-1:0] thr_i,
`ifdef LIF_REFRACTORY_EN
  input  logic [RW-1:0]    refrac_i,
  output logic [RW-1:0]    refrac_o,
`endif
  output logic [WIDTH-1:0] mem_o,
  output logic             spike_o
);

  logic [WIDTH-1:0] sum;
  logic             fire;

  assign sum = WIDTH'(lif_sat_add(
    32'(cur_i),
    32'(mem_i >> LEAK_SHIFT),
    WIDTH
  ));
  assign fire = (sum >= thr_i);

`ifdef LIF_REFRACTORY_EN
  always_comb begin
    mem_o    = fire ? '0 : sum;
    spike_o  = fire;
    refrac_o = fire ? RW'(REFRAC) : '0;
    // Held channels ignore their input.
    if (refrac_i != '0) begin
      mem_o    = '0;
      spike_o  = 1'b0;
      refrac_o = refrac_i - 1'b1;
    end
  end
`else
  assign mem_o   = fire ? '0 : sum;
  assign spike_o = fire;
`endif

endmodule

// File: rtl/lif_neuron_array.sv
// Time-multiplexed LIF neuron array, one channel per sweep cycle.
// LIF_REFRACTORY_EN enables per-channel refractory counters.
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 8,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRAC     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      step_valid,
  output logic                      step_ready,
  input  logic [CHANNELS*WIDTH-1:0] current,
  input  logic [WIDTH-1:0]          threshold,
  output logic [CHANNELS-1:0]       spike,
  output logic                      spike_valid,
  input  logic [LIF_IDX_W(CHANNELS)-1:0] state_sel,
  output logic [WIDTH-1:0]          state_out
);

  localparam int IW = LIF_IDX_W(CHANNELS);

  if (CHANNELS < 1 || REFRAC < 1 ||
      LEAK_SHIFT < 1 || LEAK_SHIFT > WIDTH - 1)
  begin : g_bad_cfg
    $error("lif_neuron_array: bad parameters");
  end

  lif_state_t                state_q;
  logic [IW-1:0]             idx_q;
  logic [CHANNELS*WIDTH-1:0] cur_q;
  logic [WIDTH-1:0]          thr_q;
  logic [WIDTH-1:0]          mem_q [CHANNELS];
  logic [CHANNELS-1:0]       pend_q;
  logic [CHANNELS-1:0]       spike_q;
  logic                      spike_valid_q;
  logic [WIDTH-1:0]          mem_d;
  logic                      spk_d;

`ifdef LIF_REFRACTORY_EN
  localparam int RW = $clog2(REFRAC + 1);
  logic [RW-1:0] refrac_q [CHANNELS];
  logic [RW-1:0] refrac_d;
`endif

  lif_update #(
    .WIDTH      (WIDTH),
    .LEAK_SHIFT (LEAK_SHIFT)
`ifdef LIF_REFRACTORY_EN
    ,
    .REFRAC     (REFRAC),
    .RW         (RW)
`endif
  ) u_upd (
    .mem_i    (mem_q[idx_q]),
    .cur_i    (cur_q[32'(idx_q)*WIDTH +: WIDTH]),
    .thr_i    (thr_q),
`ifdef LIF_REFRACTORY_EN
    .refrac_i (refrac_q[idx_q]),
    .refrac_o (refrac_d),
`endif
    .mem_o    (mem_d),
    .spike_o  (spk_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cur_q         <= '0;
      thr_q         <= '0;
      pend_q        <= '0;
      spike_q       <= '0;
      spike_valid_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        mem_q[i] <= '0;
`ifdef LIF_REFRACTORY_EN
        refrac_q[i] <= '0;
`endif
      end
    end else begin
      spike_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (step_valid) begin
            cur_q   <= current;
            thr_q   <= threshold;
            idx_q   <= '0;
            state_q <= SWEEP;
          end
        end
        SWEEP: begin
          mem_q[idx_q]  <= mem_d;
          pend_q[idx_q] <= spk_d;
`ifdef LIF_REFRACTORY_EN
          refrac_q[idx_q] <= refrac_d;
`endif
          if (idx_q == IW'(CHANNELS - 1)) begin
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          spike_q       <= pend_q;
          spike_valid_q <= 1'b1;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign step_ready  = (state_q == IDLE) && !rst;
  assign spike       = spike_q;
  assign spike_valid = spike_valid_q;

  always_comb begin
    state_out = '0;
    if (32'(state_sel) < CHANNELS) begin
      state_out = mem_q[state_sel];
    end
  end

endmodule
